// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32I control sequencer.
//
// Walks each instruction through FETCH -> DECODE -> EXECUTE -> [MEMORY] ->
// [WRITEBACK] -> FETCH. It raises the memory requests and datapath strobes
// for each step, counts retired instructions and parks in TRAP when it sees
// an unknown opcode.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   instruction  : instruction register, stable from DECODE until back in FETCH
//   imem_ack     : instruction memory data valid (only sampled in FETCH)
//   dmem_ack     : data access completes (only sampled in MEMORY)
//   branch_taken : ALU compare result, sampled in EXECUTE
//   imem_req     : instruction fetch request
//   ir_we        : instruction register load strobe
//   dmem_re/we   : data read / write request
//   rf_we        : register file write strobe
//   wb_sel       : writeback source (0 ALU, 1 mem, 2 pc+4, 3 imm)
//   pc_we/pc_sel : PC update strobe / next-PC source (0 pc+4, 1 pc+imm, 2 rs1+imm)
//   retire       : one-cycle pulse per completed instruction
//   illegal      : held high while trapped
//   state        : current state code
//   instret      : retired instruction count, wraps silently

package control_fsm_pkg;
  typedef logic [31:0] instruction_t;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;
endpackage

module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  instruction_t     instruction,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             retire,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  // The instruction register is stable for the whole instruction, so the
  // opcode class is decoded combinationally rather than latched in DECODE.
  logic [6:0] opcode;
  logic       is_load, is_store, is_branch, is_lui, is_jal, is_jalr, legal;
  logic       rd_nz;
  logic       unused_bits;

  assign opcode      = instruction[6:0];
  assign is_load     = (opcode == OP_LOAD);
  assign is_store    = (opcode == OP_S);
  assign is_branch   = (opcode == OP_B);
  assign is_lui      = (opcode == OP_LUI);
  assign is_jal      = (opcode == OP_JAL);
  assign is_jalr     = (opcode == OP_JALR);
  assign legal       = is_load | is_store | is_branch | is_lui | is_jal | is_jalr |
                       (opcode == OP_R) | (opcode == OP_I) | (opcode == OP_AUIPC);
  // Writes to x0 are suppressed.
  assign rd_nz       = |instruction[11:7];
  assign unused_bits = ^instruction[31:12];

  // Outputs are decoded from the current state plus the acks so that ir_we and
  // the store/branch retire land in the same cycle as the qualifying input.
  // Every output is gated by rst_n so reset silences them asynchronously,
  // including a request that is in flight.
  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_re   = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    retire    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = legal ? EXECUTE : TRAP;
      end
      EXECUTE: begin
        if (is_load || is_store) begin
          state_d = MEMORY;
        end else if (is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken ? 2'd1 : 2'd0;
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = WRITEBACK;
        end
      end
      MEMORY: begin
        dmem_re = is_load;
        dmem_we = !is_load;
        if (dmem_ack) begin
          if (is_load) begin
            state_d = WRITEBACK;
          end else begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end
        end
      end
      WRITEBACK: begin
        rf_we = rd_nz;
        // wb_sel stays 0 unless the register file is actually written.
        if (rd_nz) begin
          if (is_load)                wb_sel = 2'd1;
          else if (is_jal || is_jalr) wb_sel = 2'd2;
          else if (is_lui)            wb_sel = 2'd3;
          else                        wb_sel = 2'd0;
        end
        pc_we   = 1'b1;
        pc_sel  = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        retire  = 1'b1;
        state_d = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    instret_d = instret_q + CNT_W'(retire);

    if (!rst_n) begin
      imem_req  = 1'b0;
      ir_we     = 1'b0;
      dmem_re   = 1'b0;
      dmem_we   = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = 2'd0;
      pc_we     = 1'b0;
      pc_sel    = 2'd0;
      retire    = 1'b0;
      illegal   = 1'b0;
      state_d   = FETCH;
      instret_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;
  import control_fsm_pkg::*;

  localparam int CNT_W = 4;
  localparam int K_ALU = 0, K_BR = 1, K_LOAD = 2, K_STORE = 3;

  typedef struct {
    logic [31:0] instr;
    bit          bt;
    int          kind;
    int          iw;      // FETCH wait cycles before imem_ack
    int          dw;      // MEMORY wait cycles before dmem_ack
    int          cycles;  // expected FETCH-to-retire length
    bit          rf;
    logic [1:0]  wb;
    logic [1:0]  pcs;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  instruction_t     instruction;
  logic             imem_ack, dmem_ack, branch_taken;
  logic             imem_req, ir_we, dmem_re, dmem_we, rf_we, pc_we, retire, illegal;
  logic [1:0]       wb_sel, pc_sel;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_instret = '0;
  vec_t vecs[13];
  vec_t sb_q[$];

  control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
    .retire(retire), .illegal(illegal), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Drive one instruction from its first FETCH cycle to its retire cycle.
  task automatic run_vec(input vec_t v);
    int mem_lo, mem_hi, es;
    bit last, mem;
    logic [31:0] got, exp;
    vec_t e;
    sb_q.push_back(v);
    instruction  = v.instr;
    branch_taken = v.bt;
    mem    = (v.kind == K_LOAD) || (v.kind == K_STORE);
    mem_lo = v.iw + 3;
    mem_hi = v.iw + 3 + v.dw;
    for (int c = 0; c < v.cycles; c++) begin
      @(negedge clk);
      imem_ack = (c == v.iw) ? 1'b1 : ((c < v.iw) ? 1'b0 : 1'($urandom_range(0, 1)));
      if (mem && c >= mem_lo) dmem_ack = (c == mem_hi);
      else                    dmem_ack = 1'($urandom_range(0, 1));
      #1;
      if (c <= v.iw)          es = 0;
      else if (c == v.iw + 1) es = 1;
      else if (c == v.iw + 2) es = 2;
      else if (mem)           es = (c <= mem_hi) ? 3 : 4;
      else                    es = 4;
      last = (c == v.cycles - 1);
      got = {22'd0, state, imem_req, ir_we, dmem_re, dmem_we, retire, illegal,
             last ? 1'b0 : (rf_we | pc_we | (|wb_sel) | (|pc_sel))};
      exp = {22'd0, 3'(es), es == 0, c == v.iw, es == 3 && v.kind == K_LOAD,
             es == 3 && v.kind == K_STORE, last, 1'b0, 1'b0};
      check("cycle", got, exp);
      if (retire) begin
        if (sb_q.size() == 0) begin
          check("sb_empty_on_retire", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("retire_ctrl", {26'd0, rf_we, wb_sel, pc_we, pc_sel},
                {26'd0, e.rf, e.wb, 1'b1, e.pcs});
          check("latency", 32'(c + 1), 32'(e.cycles));
        end
      end
    end
    @(posedge clk);
    #1;
    exp_instret = exp_instret + 1'b1;
    check("instret", 32'(instret), 32'(exp_instret));
  endtask

  initial begin
    vecs[0]  = '{32'h002081B3, 1'b0, K_ALU,   0, 0, 4, 1'b1, 2'd0, 2'd0}; // add x3,x1,x2
    vecs[1]  = '{32'h0000A083, 1'b0, K_LOAD,  0, 2, 7, 1'b1, 2'd1, 2'd0}; // lw, 3 MEMORY cycles
    vecs[2]  = '{32'h00208463, 1'b1, K_BR,    0, 0, 3, 1'b0, 2'd0, 2'd1}; // beq taken
    vecs[3]  = '{32'h00208463, 1'b0, K_BR,    2, 0, 5, 1'b0, 2'd0, 2'd0}; // beq not taken, fetch wait 2
    vecs[4]  = '{32'h00000013, 1'b0, K_ALU,   0, 0, 4, 1'b0, 2'd0, 2'd0}; // addi x0,x0,0
    vecs[5]  = '{32'h0020A023, 1'b0, K_STORE, 0, 0, 4, 1'b0, 2'd0, 2'd0}; // sw
    vecs[6]  = '{32'h123452B7, 1'b0, K_ALU,   0, 0, 4, 1'b1, 2'd3, 2'd0}; // lui x5
    vecs[7]  = '{32'h00000317, 1'b0, K_ALU,   0, 0, 4, 1'b1, 2'd0, 2'd0}; // auipc x6
    vecs[8]  = '{32'h000000EF, 1'b0, K_ALU,   0, 0, 4, 1'b1, 2'd2, 2'd1}; // jal x1
    vecs[9]  = '{32'h00008067, 1'b0, K_ALU,   0, 0, 4, 1'b0, 2'd0, 2'd2}; // jalr x0,0(x1)
    vecs[10] = '{32'h000100E7, 1'b0, K_ALU,   1, 0, 5, 1'b1, 2'd2, 2'd2}; // jalr x1,0(x2)
    vecs[11] = '{32'h0000A083, 1'b0, K_LOAD,  1, 0, 6, 1'b1, 2'd1, 2'd0}; // lw, fetch wait 1
    vecs[12] = '{32'h00500093, 1'b0, K_ALU,   0, 1, 4, 1'b1, 2'd0, 2'd0}; // addi x1,x0,5

    // Reset held with acks asserted: everything must stay quiet.
    rst_n = 1'b0; instruction = '0; imem_ack = 1'b1; dmem_ack = 1'b1; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_outputs", {17'd0, state, imem_req, ir_we, dmem_re, dmem_we, rf_we, wb_sel,
                            pc_we, pc_sel, retire, illegal, 4'(instret)}, 32'd0);
    rst_n = 1'b1; imem_ack = 1'b0;
    #1;
    check("imem_req_after_reset", {31'd0, imem_req}, 32'd1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Three more retires take the 4-bit counter 13 -> 14 -> 15 -> 0.
    for (int i = 0; i < 3; i++) run_vec(vecs[0]);
    check("instret_wrap", 32'(instret), 32'd0);

    // Reset in the middle of a load's MEMORY wait.
    run_vec(vecs[0]);
    instruction = 32'h0000A083;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      imem_ack = (c == 0);
      dmem_ack = 1'b0;
    end
    #1;
    check("mem_wait_re", {28'd0, state, dmem_re}, {28'd0, 3'd3, 1'b1});
    rst_n = 1'b0;
    #1;
    check("mid_mem_reset", {24'd0, state, dmem_re, retire, imem_req, 4'(instret)}, 32'd0);
    dmem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; dmem_ack = 1'b0;
    exp_instret = '0;
    #1;
    check("post_reset_fetch", {28'd0, state, imem_req}, 32'd1);

    // Illegal opcode: park in TRAP until reset.
    run_vec(vecs[0]);
    instruction = 32'h00000000;
    @(negedge clk); imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
    #1;
    check("decode_illegal", 32'(state), 32'd1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      imem_ack = 1'b1; dmem_ack = 1'b1;
      #1;
      check("trap_hold", {20'd0, state, illegal, imem_req, ir_we, dmem_re, dmem_we,
                          rf_we, pc_we, retire, 1'b0},
            {20'd0, 3'd5, 1'b1, 8'd0});
    end
    rst_n = 1'b0;
    #1;
    check("trap_reset", {24'd0, state, illegal, 4'(instret)}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    check("trap_exit_fetch", {28'd0, state, imem_req}, 32'd1);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port instruction, input, instruction_t (32): current instruction-register contents, stable from DECODE until the return to FETCH.
REQ-005 SHALL have port imem_ack, input, 1: instruction memory has data valid this cycle.
REQ-006 SHALL have port dmem_ack, input, 1: data memory access completes this cycle.
REQ-007 SHALL have port branch_taken, input, 1: ALU compare result, valid in EXECUTE.
REQ-008 SHALL have port imem_req, output, 1: instruction fetch request.
REQ-009 SHALL have port ir_we, output, 1: instruction-register load strobe.
REQ-010 SHALL have ports dmem_re and dmem_we, outputs, 1 each: data read and write requests.
REQ-011 SHALL have port rf_we, output, 1: register-file write strobe.
REQ-012 SHALL have port wb_sel, output, 2: writeback source (0 ALU, 1 memory, 2 pc+4, 3 immediate).
REQ-013 SHALL have ports pc_we (output, 1) and pc_sel (output, 2): PC update strobe and next-PC source (0 pc+4, 1 pc+imm, 2 rs1+imm).
REQ-014 SHALL have ports retire (output, 1), illegal (output, 1) and state (output, 3): retire pulse, trap flag and current state.
REQ-015 SHALL have port instret, output, CNT_W: count of retired instructions.

Function
REQ-016 SHALL encode state as FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5; codes 6 and 7 are unreachable and SHALL go to FETCH.
REQ-017 SHALL classify instruction[6:0] in DECODE as follows:
- 0110011 R
- 0010011 I
- 0000011 load
- 0100011 S
- 1100011 B
- 0110111 LUI
- 0010111 AUIPC
- 1101111 JAL
- 1100111 JALR
- any other value is illegal.
REQ-018 SHALL handle FETCH as follows: imem_req=1; on imem_ack, ir_we=1 for that cycle and next state DECODE; otherwise stay in FETCH.
REQ-019 SHALL handle DECODE as follows: illegal opcode goes to TRAP; any legal opcode goes to EXECUTE; no strobes.
REQ-020 SHALL handle EXECUTE as follows:
- load or S goes to MEMORY.
- B: pc_we=1, pc_sel=branch_taken?1:0, retire=1, next state FETCH.
- all other types go to WRITEBACK.
REQ-021 SHALL handle MEMORY as follows:
- dmem_re (load) or dmem_we (S) held high until dmem_ack.
- On ack, load goes to WRITEBACK.
- On ack, S: pc_we=1, pc_sel=0, retire=1, next state FETCH.
REQ-022 SHALL handle WRITEBACK for one cycle and return to FETCH, driving the following:
- rf_we=1 unless instruction[11:7]==0.
- wb_sel: load 1, JAL/JALR 2, LUI 3, else 0.
- pc_we=1; pc_sel: JAL 1, JALR 2, else 0.
- retire=1.
REQ-023 SHALL handle TRAP as follows: illegal=1 held; all request/strobe outputs 0; the block leaves TRAP only via reset.
REQ-024 SHALL keep all strobes (ir_we, rf_we, pc_we, retire) as single-cycle pulses in exactly the cycle named.
REQ-025 SHALL drive wb_sel and pc_sel to 0 when not qualified by rf_we or pc_we.
REQ-026 SHALL increment instret by 1 on each retire, wrapping from all-ones to 0 without a flag.
REQ-027 SHALL use the following minimum latencies with acks in the first possible cycle:
- B: 3 cycles.
- R, I, LUI, AUIPC, JAL, JALR, S: 4 cycles.
- load: 5 cycles.
- each ack wait-cycle adds 1.
REQ-028 SHALL ignore imem_ack outside FETCH and dmem_ack outside MEMORY.

Reset
REQ-029 SHALL, while rst_n=0, force the following asynchronously:
- state to FETCH.
- instret to 0.
- illegal to 0.
- every output to 0, including imem_req.
REQ-030 SHALL assert imem_req in the first cycle after rst_n rises.
REQ-031 SHALL drop dmem_re/dmem_we immediately when reset is asserted mid-MEMORY, with no retire.

Verification
REQ-032 SHALL pass this scenario: instruction 0x002081B3 (add x3,x1,x2), imem_ack in first FETCH cycle -> state 0,1,2,4,0; in cycle 4 rf_we=1, wb_sel=0, pc_we=1, pc_sel=0, retire=1; instret 0->1.
REQ-033 SHALL pass this scenario: instruction 0x0000A083 (lw x1,0(x1)), dmem_ack 3 cycles after MEMORY entry -> dmem_re high 3 cycles, then WRITEBACK with wb_sel=1, rf_we=1; 7 cycles total.
REQ-034 SHALL pass this scenario: instruction 0x00208463 (beq), branch_taken=1 -> in EXECUTE pc_we=1, pc_sel=1, retire=1; rf_we never asserted; next state FETCH.
REQ-035 SHALL pass this scenario: instruction 0x00000013 (addi x0,x0,0) -> WRITEBACK with rf_we=0, retire=1, pc_we=1.
REQ-036 SHALL pass this scenario: instruction 0x00000000 -> DECODE to TRAP, illegal=1 for 20 cycles, imem_req=0 throughout; rst_n pulse low -> state 0, illegal 0, instret 0.
REQ-037 SHALL pass this scenario: instret preset via 2^CNT_W-1 retires with CNT_W=4 (15 retires), one more retire -> instret 0.
